// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu
//   Registered four-function ALU with valid/ready handshakes on both sides.
//   Compare and the two add operations finish at the accept edge. Multiply
//   uses an iterative shift-add engine that takes WIDTH further edges.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  operands and select are valid
//   in_ready  block can accept an operation (IDLE only)
//   select    00 compare, 01 multiply, 10 X+(Y>>1), 11 X+Y+1
//   X, Y      WIDTH-bit operands
//   out_valid result and flags are valid (DONE only)
//   out_ready consumer accepts the result
//   F         WIDTH-bit result
//   cout      carry / inequality / high-product flag
//   overflow  two's-complement overflow of the add operations
//   zero      result-zero flag
//   negative  F[WIDTH-1] for the add operations
// ---------------------------------------------------------------------------
module seq_alu #(
   parameter int WIDTH = 5,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       select,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] F,
   output logic             cout,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Result word: flags plus F, registered as one unit.
   typedef struct packed {
      logic             c;
      logic             o;
      logic             z;
      logic             n;
      logic [WIDTH-1:0] f;
   } res_t;

   state_t               state_q;
   state_t               state_d;
   res_t                 res_q;
   logic [2*WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]     mplier_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [2*WIDTH-1:0]   acc_next;
   logic [CNT_W-1:0]     cnt_q;
   logic                 accept;
   logic                 out_fire;
   logic                 mul_last;

   // a + b + cin with carry-out and signed overflow. The carry into the MSB
   // is recovered as sum[MSB] ^ a[MSB] ^ b[MSB].
   function automatic res_t add_res(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic             cin);
      logic [WIDTH:0] sum;
      res_t           r;
      sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      r.f  = sum[WIDTH-1:0];
      r.c  = sum[WIDTH];
      r.o  = sum[WIDTH-1] ^ a[WIDTH-1] ^ b[WIDTH-1] ^ sum[WIDTH];
      r.z  = (sum[WIDTH-1:0] == '0);
      r.n  = sum[WIDTH-1];
      return r;
   endfunction

   function automatic res_t cmp_res(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b);
      res_t r;
      r.f = '0;
      r.c = (a != b);
      r.o = 1'b0;
      r.z = 1'b1;
      r.n = 1'b0;
      return r;
   endfunction

   // Full product: low half is F, any high bit raises cout.
   function automatic res_t mul_res(input logic [2*WIDTH-1:0] p);
      res_t r;
      r.f = p[WIDTH-1:0];
      r.c = |p[2*WIDTH-1:WIDTH];
      r.o = 1'b0;
      r.z = (p[WIDTH-1:0] == '0);
      r.n = 1'b0;
      return r;
   endfunction

   // Single-edge operations; multiply never reaches this path.
   function automatic res_t direct_res(input logic [1:0]       sel,
                                       input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
      res_t r;
      case (sel)
         2'b00:   r = cmp_res(a, b);
         2'b10:   r = add_res(a, {1'b0, b[WIDTH-1:1]}, 1'b0);
         2'b11:   r = add_res(a, b, 1'b1);
         default: r = '0;
      endcase
      return r;
   endfunction

   assign accept   = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;
   assign mul_last = (state_q == MUL) && (cnt_q == CNT_W'(WIDTH - 1));
   assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

   // ---- state register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---- next-state logic ----
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = (select == 2'b01) ? MUL : DONE;
            end
         end
         MUL: begin
            if (mul_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_fire) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---- handshake outputs ----
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // ---- operand capture, shift-add iteration and result register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else if (accept) begin
         if (select == 2'b01) begin
            mcand_q  <= {{WIDTH{1'b0}}, X};
            mplier_q <= Y;
            acc_q    <= '0;
            cnt_q    <= '0;
         end else begin
            res_q <= direct_res(select, X, Y);
         end
      end else if (state_q == MUL) begin
         acc_q    <= acc_next;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CNT_W'(1);
         if (mul_last) begin
            res_q <= mul_res(acc_next);
         end
      end
   end

   assign F        = res_q.f;
   assign cout     = res_q.c;
   assign overflow = res_q.o;
   assign zero     = res_q.z;
   assign negative = res_q.n;

endmodule
